// File: rtl/sequencer.sv
// sequencer: multi-cycle control sequencer for the cpu datapath.
// Accepts one RV64I instruction at a time over a valid/ready handshake,
// decodes it and steps it through decode, execute, an optional load-data
// wait and writeback. It drives the datapath controls: register-file
// addresses and write strobe, immediate, operand/writeback/extension mux
// selects and the ALU operation. It then reports completion.
//
// Optional feature macro: SEQUENCER_TIMEOUT_EN
//   When defined, the load-data wait is bounded to TIMEOUT_CYCLES cycles
//   and a one-cycle sequencer_timeout pulse is raised on expiry.
//   When undefined, the wait is unbounded and sequencer_timeout is 0.
//
// Ports:
//   sequencer_clk / sequencer_rst_n     clock (rising edge), async active-low reset
//   sequencer_instr[31:0]               instruction word
//   sequencer_instr_valid / _ready      instruction handshake
//   sequencer_mem_req / sequencer_mem_ack   load data request / data available
//   sequencer_rf_addr_a/_b/_write_addr  rs1 / rs2 / rd
//   sequencer_rf_write_en               register-file write strobe
//   sequencer_immediate[11:0]           instr[31:20]
//   sequencer_mux_0_sel                 ALU operand B: 0 rf port B, 1 immediate
//   sequencer_mux_1_sel                 writeback source: 0 ALU, 1 memory
//   sequencer_mux_2_sel                 immediate extension: 0 sign, 1 zero
//   sequencer_alu_operation[2:0]        ADD SUB AND OR XOR SLL SRL SLT (000..111)
//   sequencer_done / _illegal / _timeout    one-cycle status pulses
//   sequencer_retired[COUNT_WIDTH-1:0]  completed-instruction count (wraps)
//
// state        | meaning
// -------------+------------------------------------------------------
// ST_IDLE      | ready for a new instruction
// ST_DECODE    | latched instruction checked for legality and decoded
// ST_EXECUTE   | controls driven, ALU evaluates
// ST_MEM       | load data requested, waiting for mem_ack
// ST_WRITEBACK | write strobe (unless rd=0), done pulse, count retired
module sequencer #(
   parameter int COUNT_WIDTH    = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                   sequencer_clk,
   input  logic                   sequencer_rst_n,
   input  logic [31:0]            sequencer_instr,
   input  logic                   sequencer_instr_valid,
   output logic                   sequencer_instr_ready,
   output logic                   sequencer_mem_req,
   input  logic                   sequencer_mem_ack,
   output logic [4:0]             sequencer_rf_addr_a,
   output logic [4:0]             sequencer_rf_addr_b,
   output logic [4:0]             sequencer_rf_write_addr,
   output logic                   sequencer_rf_write_en,
   output logic [11:0]            sequencer_immediate,
   output logic                   sequencer_mux_0_sel,
   output logic                   sequencer_mux_1_sel,
   output logic                   sequencer_mux_2_sel,
   output logic [2:0]             sequencer_alu_operation,
   output logic                   sequencer_done,
   output logic                   sequencer_illegal,
   output logic                   sequencer_timeout,
   output logic [COUNT_WIDTH-1:0] sequencer_retired
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DECODE,
      ST_EXECUTE,
      ST_MEM,
      ST_WRITEBACK
   } state_t;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLL = 3'b101;
   localparam logic [2:0] ALU_SRL = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   state_t      state;
   logic [31:0] instr_q;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       dec_legal;
   logic       dec_imm;
   logic       dec_load;
   logic       dec_zext;
   logic [2:0] dec_alu;
   logic       wb_enter;
   logic       tmo_expire;

   assign opcode = instr_q[6:0];
   assign funct3 = instr_q[14:12];
   assign funct7 = instr_q[31:25];

   // Ready is a decode of the state register, forced low while reset is held.
   assign sequencer_instr_ready = sequencer_rst_n && (state == ST_IDLE);

   always_comb begin
      dec_legal = 1'b0;
      dec_imm   = 1'b0;
      dec_load  = 1'b0;
      dec_zext  = 1'b0;
      dec_alu   = ALU_ADD;
      case (opcode)
         OPC_OP: begin
            if (funct7 == 7'b0000000) begin
               dec_legal = 1'b1;
               case (funct3)
                  3'b000:  dec_alu = ALU_ADD;
                  3'b001:  dec_alu = ALU_SLL;
                  3'b010:  dec_alu = ALU_SLT;
                  3'b100:  dec_alu = ALU_XOR;
                  3'b101:  dec_alu = ALU_SRL;
                  3'b110:  dec_alu = ALU_OR;
                  3'b111:  dec_alu = ALU_AND;
                  default: dec_legal = 1'b0;
               endcase
            end else if ((funct7 == 7'b0100000) && (funct3 == 3'b000)) begin
               dec_legal = 1'b1;
               dec_alu   = ALU_SUB;
            end
         end
         OPC_OP_IMM: begin
            dec_imm   = 1'b1;
            dec_legal = 1'b1;
            case (funct3)
               3'b000:  dec_alu = ALU_ADD;
               3'b010:  dec_alu = ALU_SLT;
               3'b100:  dec_alu = ALU_XOR;
               3'b110:  dec_alu = ALU_OR;
               3'b111:  dec_alu = ALU_AND;
               // Shift amount is 6 bits on RV64; anything above it (SRAI) is rejected.
               3'b001: begin
                  dec_alu   = ALU_SLL;
                  dec_zext  = 1'b1;
                  dec_legal = (instr_q[31:26] == 6'd0);
               end
               3'b101: begin
                  dec_alu   = ALU_SRL;
                  dec_zext  = 1'b1;
                  dec_legal = (instr_q[31:26] == 6'd0);
               end
               default: dec_legal = 1'b0;
            endcase
         end
         OPC_LOAD: begin
            dec_imm   = 1'b1;
            dec_load  = 1'b1;
            dec_legal = (funct3 == 3'b011);
         end
         default: dec_legal = 1'b0;
      endcase
   end

   // mux_1_sel is only set for loads, so it doubles as the "is load" flag.
   assign wb_enter = ((state == ST_EXECUTE) && !sequencer_mux_1_sel) ||
                     ((state == ST_MEM) && sequencer_mem_ack);

`ifdef SEQUENCER_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMR_W-1:0] tmo_cnt;
   logic             timeout_q;

   // Down-counter reaches terminal count on the last allowed ack-low cycle.
   assign tmo_expire        = (state == ST_MEM) && !sequencer_mem_ack && (tmo_cnt == '0);
   assign sequencer_timeout = timeout_q;
`else
   assign tmo_expire        = 1'b0;
   assign sequencer_timeout = 1'b0;
`endif

   always_ff @(posedge sequencer_clk or negedge sequencer_rst_n) begin
      if (!sequencer_rst_n) begin
         state                   <= ST_IDLE;
         instr_q                 <= '0;
         sequencer_mem_req       <= 1'b0;
         sequencer_rf_addr_a     <= '0;
         sequencer_rf_addr_b     <= '0;
         sequencer_rf_write_addr <= '0;
         sequencer_rf_write_en   <= 1'b0;
         sequencer_immediate     <= '0;
         sequencer_mux_0_sel     <= 1'b0;
         sequencer_mux_1_sel     <= 1'b0;
         sequencer_mux_2_sel     <= 1'b0;
         sequencer_alu_operation <= '0;
         sequencer_done          <= 1'b0;
         sequencer_illegal       <= 1'b0;
         sequencer_retired       <= '0;
`ifdef SEQUENCER_TIMEOUT_EN
         tmo_cnt                 <= '0;
         timeout_q               <= 1'b0;
`endif
      end else begin
         sequencer_rf_write_en <= 1'b0;
         sequencer_done        <= 1'b0;
         sequencer_illegal     <= 1'b0;
`ifdef SEQUENCER_TIMEOUT_EN
         timeout_q             <= 1'b0;
`endif

         if (wb_enter) begin
            sequencer_rf_write_en <= (sequencer_rf_write_addr != 5'd0);
            sequencer_done        <= 1'b1;
            sequencer_retired     <= sequencer_retired + COUNT_WIDTH'(1);
         end

         // Controls return to zero whenever an instruction leaves the datapath.
         if ((state == ST_WRITEBACK) || tmo_expire) begin
            sequencer_mem_req       <= 1'b0;
            sequencer_rf_addr_a     <= '0;
            sequencer_rf_addr_b     <= '0;
            sequencer_rf_write_addr <= '0;
            sequencer_immediate     <= '0;
            sequencer_mux_0_sel     <= 1'b0;
            sequencer_mux_1_sel     <= 1'b0;
            sequencer_mux_2_sel     <= 1'b0;
            sequencer_alu_operation <= '0;
         end

         case (state)
            ST_IDLE: begin
               if (sequencer_instr_valid) begin
                  instr_q <= sequencer_instr;
                  state   <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (!dec_legal) begin
                  sequencer_illegal <= 1'b1;
                  state             <= ST_IDLE;
               end else begin
                  sequencer_rf_addr_a     <= instr_q[19:15];
                  sequencer_rf_addr_b     <= dec_imm ? 5'd0 : instr_q[24:20];
                  sequencer_rf_write_addr <= instr_q[11:7];
                  sequencer_immediate     <= instr_q[31:20];
                  sequencer_mux_0_sel     <= dec_imm;
                  sequencer_mux_1_sel     <= dec_load;
                  sequencer_mux_2_sel     <= dec_zext;
                  sequencer_alu_operation <= dec_alu;
                  state                   <= ST_EXECUTE;
               end
            end
            ST_EXECUTE: begin
               if (sequencer_mux_1_sel) begin
                  sequencer_mem_req <= 1'b1;
`ifdef SEQUENCER_TIMEOUT_EN
                  tmo_cnt           <= TMR_W'(TIMEOUT_CYCLES - 1);
`endif
                  state             <= ST_MEM;
               end else begin
                  state <= ST_WRITEBACK;
               end
            end
            ST_MEM: begin
               if (sequencer_mem_ack) begin
                  sequencer_mem_req <= 1'b0;
                  state             <= ST_WRITEBACK;
               end
`ifdef SEQUENCER_TIMEOUT_EN
               else if (tmo_expire) begin
                  timeout_q <= 1'b1;
                  state     <= ST_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt - TMR_W'(1);
               end
`endif
            end
            ST_WRITEBACK: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sequencer.sv
// tb_sequencer: self-checking bench for the sequencer.
// A timeline model turns each accepted instruction into the list of output
// vectors expected on the following cycles; a compare process checks the DUT
// against it every cycle, and directed literal checks pin the model itself.
module tb_sequencer;

   localparam int CW  = 3;
   localparam int TMO = 255;

   logic          clk;
   logic          rst_n;
   logic [31:0]   instr;
   logic          valid;
   logic          ready;
   logic          mem_req;
   logic          mem_ack;
   logic [4:0]    addr_a;
   logic [4:0]    addr_b;
   logic [4:0]    waddr;
   logic          we;
   logic [11:0]   imm;
   logic          m0;
   logic          m1;
   logic          m2;
   logic [2:0]    alu;
   logic          done;
   logic          illegal;
   logic          timeout;
   logic [CW-1:0] retired;

   sequencer #(.COUNT_WIDTH(CW), .TIMEOUT_CYCLES(TMO)) dut (
      .sequencer_clk           (clk),
      .sequencer_rst_n         (rst_n),
      .sequencer_instr         (instr),
      .sequencer_instr_valid   (valid),
      .sequencer_instr_ready   (ready),
      .sequencer_mem_req       (mem_req),
      .sequencer_mem_ack       (mem_ack),
      .sequencer_rf_addr_a     (addr_a),
      .sequencer_rf_addr_b     (addr_b),
      .sequencer_rf_write_addr (waddr),
      .sequencer_rf_write_en   (we),
      .sequencer_immediate     (imm),
      .sequencer_mux_0_sel     (m0),
      .sequencer_mux_1_sel     (m1),
      .sequencer_mux_2_sel     (m2),
      .sequencer_alu_operation (alu),
      .sequencer_done          (done),
      .sequencer_illegal       (illegal),
      .sequencer_timeout       (timeout),
      .sequencer_retired       (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic          ready;
      logic          mem_req;
      logic [4:0]    addr_a;
      logic [4:0]    addr_b;
      logic [4:0]    waddr;
      logic          we;
      logic [11:0]   imm;
      logic          m0;
      logic          m1;
      logic          m2;
      logic [2:0]    alu;
      logic          done;
      logic          illegal;
      logic          timeout;
      logic [CW-1:0] retired;
   } obs_t;

   typedef struct {
      logic [31:0] ins;
      bit          legal;
      logic [2:0]  alu;
   } vec_t;

   // ALU code selected by funct3 for plain ADD-family / immediate ops.
   localparam logic [2:0] F3_ALU [8] = '{3'd0, 3'd5, 3'd7, 3'd0, 3'd4, 3'd6, 3'd3, 3'd2};

   int   checks = 0;
   int   errors = 0;
   int   model_total = 0;
   bit   checking = 1'b0;
   obs_t exp_q[$];
   obs_t snap[$];
   vec_t vecs[$];

   function automatic obs_t sample();
      obs_t o;
      o.ready   = ready;
      o.mem_req = mem_req;
      o.addr_a  = addr_a;
      o.addr_b  = addr_b;
      o.waddr   = waddr;
      o.we      = we;
      o.imm     = imm;
      o.m0      = m0;
      o.m1      = m1;
      o.m2      = m2;
      o.alu     = alu;
      o.done    = done;
      o.illegal = illegal;
      o.timeout = timeout;
      o.retired = retired;
      return o;
   endfunction

   function automatic logic [CW-1:0] retired_now();
      return CW'(model_total % (1 << CW));
   endfunction

   function automatic obs_t idle_rec();
      obs_t r;
      r         = '0;
      r.ready   = 1'b1;
      r.retired = retired_now();
      return r;
   endfunction

   // Expected outputs for every cycle after the accepting edge.
   function automatic void model_push(input logic [31:0] ins, input int ack_cyc);
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      bit         is_r, is_i, is_ld, legal;
      obs_t       c, r;
      int         m;
      op    = ins[6:0];
      f3    = ins[14:12];
      f7    = ins[31:25];
      is_r  = (op == 7'b0110011);
      is_i  = (op == 7'b0010011);
      is_ld = (op == 7'b0000011);
      legal = (is_r && ((f7 == 7'h00 && f3 != 3'd3) || (f7 == 7'h20 && f3 == 3'd0))) ||
              (is_i && f3 != 3'd3 && ((f3 != 3'd1 && f3 != 3'd5) || ins[31:26] == 6'd0)) ||
              (is_ld && f3 == 3'd3);

      r         = '0;
      r.retired = retired_now();
      exp_q.push_back(r);
      if (!legal) begin
         r         = idle_rec();
         r.illegal = 1'b1;
         exp_q.push_back(r);
         return;
      end

      c         = '0;
      c.addr_a  = ins[19:15];
      c.addr_b  = is_r ? ins[24:20] : 5'd0;
      c.waddr   = ins[11:7];
      c.imm     = ins[31:20];
      c.m0      = !is_r;
      c.m1      = is_ld;
      c.m2      = is_i && (f3 == 3'd1 || f3 == 3'd5);
      c.alu     = is_ld ? 3'd0 : ((is_r && f7 == 7'h20) ? 3'd1 : F3_ALU[f3]);
      c.retired = retired_now();
      exp_q.push_back(c);

      if (is_ld) begin
         if (ack_cyc > 0) m = ack_cyc;
         else begin
`ifdef SEQUENCER_TIMEOUT_EN
            m = TMO;
`else
            m = 20;
`endif
         end
         for (int k = 0; k < m; k++) begin
            r         = c;
            r.mem_req = 1'b1;
            exp_q.push_back(r);
         end
         if (ack_cyc <= 0) begin
`ifdef SEQUENCER_TIMEOUT_EN
            r         = idle_rec();
            r.timeout = 1'b1;
            exp_q.push_back(r);
`endif
            return;
         end
      end

      model_total++;
      r         = c;
      r.we      = (ins[11:7] != 5'd0);
      r.done    = 1'b1;
      r.retired = retired_now();
      exp_q.push_back(r);
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Per-cycle compare against the model timeline.
   initial begin
      obs_t e, g;
      forever begin
         @(posedge clk);
         #1;
         if (checking) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : idle_rec();
            g = sample();
            checks++;
            if (g !== e) begin
               errors++;
               $display("FAIL cycle_check t=%0t got=%h expected=%h", $time, g, e);
            end
         end
      end
   end

   // ack_cyc: -1 holds mem_ack high throughout, 0 never acks, k>0 acks on MEM cycle k.
   task automatic issue(input logic [31:0] ins, input int ack_cyc, input bit hold, input int abort_at);
      int g;
      int n;
      snap.delete();
      g = 0;
      @(negedge clk);
      while (!ready && g < 20) begin
         @(negedge clk);
         g++;
      end
      if (!ready) begin
         chk("issue_ready", {63'd0, ready}, 64'd1);
         return;
      end
      instr = ins;
      valid = 1'b1;
      @(posedge clk);
      model_push(ins, ack_cyc);
      n = exp_q.size();
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         snap.push_back(sample());
         valid   = hold;
         mem_ack = (ack_cyc < 0) || (ack_cyc > 0 && i == 2 + ack_cyc);
         if (abort_at > 0 && i == abort_at) break;
      end
      mem_ack = 1'b0;
      if (hold) begin
         @(posedge clk);
         #2;
         valid = 1'b0;
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [4:0] rs1, input logic [6:0] op);
      return {im, rs1, f3, rd, op};
   endfunction

   initial begin
      int cnt;
      rst_n   = 1'b0;
      valid   = 1'b0;
      instr   = '0;
      mem_ack = 1'b0;
      #12;
      chk("reset_state", 64'(sample()), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n    = 1'b1;
      checking = 1'b1;
      #1;
      chk("ready_after_reset", {63'd0, ready}, 64'd1);

      // ADD x3,x1,x2 with mem_ack held high (must be ignored)
      issue(32'h002081B3, -1, 1'b0, 0);
      chk("add_len", snap.size(), 3);
      chk("add_decode_zero", 64'(snap[0]), 64'd0);
      chk("add_addr_a", snap[2].addr_a, 1);
      chk("add_addr_b", snap[2].addr_b, 2);
      chk("add_waddr", snap[2].waddr, 3);
      chk("add_alu", snap[2].alu, 0);
      chk("add_mux0", snap[2].m0, 0);
      chk("add_we", snap[2].we, 1);
      chk("add_done", snap[2].done, 1);
      chk("add_retired", snap[2].retired, 1);

      // ADDI x5,x0,-1
      issue(32'hFFF00293, 0, 1'b0, 0);
      chk("addi_imm", snap[1].imm, 12'hFFF);
      chk("addi_mux0", snap[1].m0, 1);
      chk("addi_mux2", snap[1].m2, 0);
      chk("addi_alu", snap[1].alu, 0);
      chk("addi_waddr", snap[1].waddr, 5);
      chk("addi_addr_b", snap[1].addr_b, 0);

      // SLLI x1,x1,3
      issue(32'h00309093, 0, 1'b0, 0);
      chk("slli_alu", snap[1].alu, 5);
      chk("slli_mux2", snap[1].m2, 1);
      chk("slli_imm", snap[1].imm, 12'h003);

      // LD x6,8(x1) acked on third MEM cycle
      issue(32'h0080B303, 3, 1'b0, 0);
      cnt = 0;
      foreach (snap[k]) cnt += snap[k].mem_req;
      chk("ld_len", snap.size(), 6);
      chk("ld_mem_req_cycles", cnt, 3);
      chk("ld_mux1", snap[2].m1, 1);
      chk("ld_imm", snap[2].imm, 12'h008);
      chk("ld_wb_we", snap[5].we, 1);
      chk("ld_wb_waddr", snap[5].waddr, 6);
      chk("ld_wb_mem_req", snap[5].mem_req, 0);

      // Illegal: SRAI and all-zero word
      issue(32'h40005013, 0, 1'b0, 0);
      chk("srai_len", snap.size(), 2);
      chk("srai_illegal", snap[1].illegal, 1);
      chk("srai_ready", snap[1].ready, 1);
      chk("srai_no_done", {snap[1].we, snap[1].done}, 0);
      chk("srai_retired", snap[1].retired, 4);
      issue(32'h00000000, 0, 1'b0, 0);
      chk("zero_illegal", snap[1].illegal, 1);
      chk("zero_retired", snap[1].retired, 4);

      // SUB x0,x0,x0 with valid held through execution
      issue(32'h40000033, 0, 1'b1, 0);
      chk("sub_alu", snap[1].alu, 1);
      chk("sub_we", snap[2].we, 0);
      chk("sub_done", snap[2].done, 1);
      chk("sub_retired", snap[2].retired, 5);
      @(negedge clk);
      chk("sub_not_reaccepted", {63'd0, ready}, 64'd1);

      // Remaining ALU encodings and illegal neighbours
      vecs.push_back('{enc_r(7'h00, 3'b001, 5'd7, 5'd1, 5'd2), 1'b1, 3'd5});
      vecs.push_back('{enc_r(7'h00, 3'b010, 5'd7, 5'd1, 5'd2), 1'b1, 3'd7});
      vecs.push_back('{enc_r(7'h00, 3'b011, 5'd7, 5'd1, 5'd2), 1'b0, 3'd0});
      vecs.push_back('{enc_r(7'h00, 3'b100, 5'd8, 5'd3, 5'd4), 1'b1, 3'd4});
      vecs.push_back('{enc_r(7'h00, 3'b101, 5'd8, 5'd3, 5'd4), 1'b1, 3'd6});
      vecs.push_back('{enc_r(7'h20, 3'b101, 5'd8, 5'd3, 5'd4), 1'b0, 3'd0});
      vecs.push_back('{enc_r(7'h01, 3'b000, 5'd8, 5'd3, 5'd4), 1'b0, 3'd0});
      vecs.push_back('{enc_r(7'h00, 3'b110, 5'd31, 5'd30, 5'd29), 1'b1, 3'd3});
      vecs.push_back('{enc_r(7'h00, 3'b111, 5'd31, 5'd30, 5'd29), 1'b1, 3'd2});
      vecs.push_back('{enc_i(12'h801, 3'b010, 5'd9, 5'd2, 7'b0010011), 1'b1, 3'd7});
      vecs.push_back('{enc_i(12'h801, 3'b011, 5'd9, 5'd2, 7'b0010011), 1'b0, 3'd0});
      vecs.push_back('{enc_i(12'h0F0, 3'b100, 5'd9, 5'd2, 7'b0010011), 1'b1, 3'd4});
      vecs.push_back('{enc_i(12'h0F0, 3'b110, 5'd9, 5'd2, 7'b0010011), 1'b1, 3'd3});
      vecs.push_back('{enc_i(12'h7FF, 3'b111, 5'd9, 5'd2, 7'b0010011), 1'b1, 3'd2});
      vecs.push_back('{enc_i(12'h021, 3'b101, 5'd10, 5'd10, 7'b0010011), 1'b1, 3'd6});
      vecs.push_back('{enc_i(12'h010, 3'b010, 5'd10, 5'd1, 7'b0000011), 1'b0, 3'd0});
      vecs.push_back('{enc_r(7'h00, 3'b000, 5'd9, 5'd9, 5'd9), 1'b1, 3'd0});
      foreach (vecs[k]) begin
         issue(vecs[k].ins, 0, 1'b0, 0);
         if (vecs[k].legal) begin
            chk($sformatf("vec%0d_alu", k), snap[1].alu, vecs[k].alu);
            chk($sformatf("vec%0d_done", k), snap[2].done, 1);
         end else begin
            chk($sformatf("vec%0d_illegal", k), snap[1].illegal, 1);
         end
      end
      @(negedge clk);
      chk("retired_wrap", retired, 1);

      // Reset asserted during MEM
      issue(32'h0080B303, 0, 1'b0, 5);
      chk("rst_pre_mem_req", snap[4].mem_req, 1);
      #2;
      checking = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk("rst_mid_outputs", 64'(sample()), 64'd0);
      exp_q.delete();
      model_total = 0;
      @(posedge clk);
      #1;
      chk("rst_hold_outputs", 64'(sample()), 64'd0);
      @(negedge clk);
      rst_n    = 1'b1;
      checking = 1'b1;
      issue(32'h002081B3, 0, 1'b0, 0);
      chk("post_rst_retired", snap[2].retired, 1);

`ifdef SEQUENCER_TIMEOUT_EN
      issue(32'h0080B303, 0, 1'b0, 0);
      cnt = 0;
      foreach (snap[k]) cnt += snap[k].mem_req;
      chk("tmo_mem_req_cycles", cnt, TMO);
      chk("tmo_pulse", snap[snap.size() - 1].timeout, 1);
      cnt = 0;
      foreach (snap[k]) cnt += snap[k].we + snap[k].done + snap[k].timeout;
      chk("tmo_single_pulse_no_write", cnt, 1);
      chk("tmo_retired", snap[snap.size() - 1].retired, 1);
`endif

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sequencer.md
Name: sequencer

Overview:
- Multi-cycle control sequencer for the cpu datapath.
- Accepts one 32-bit RV64I instruction at a time over a valid/ready handshake and decodes it.
- Drives the datapath control inputs: register-file addresses and write enable, 12-bit immediate, three mux selects, 3-bit ALU operation.
- Sequences the instruction through decode, execute, optional memory wait and writeback, then reports completion.

Parameters:
COUNT_WIDTH, 16, width of retired-instruction counter (wraps).
TIMEOUT_CYCLES, 255, memory wait limit; used only with SEQUENCER_TIMEOUT_EN.

Ports:
sequencer_clk  in  1  single clock, rising edge
sequencer_rst_n  in  1  asynchronous active-low reset
sequencer_instr  in  32  instruction word
sequencer_instr_valid  in  1  instruction offered
sequencer_instr_ready  out  1  sequencer can accept
sequencer_mem_req  out  1  load data request
sequencer_mem_ack  in  1  load data available
sequencer_rf_addr_a  out  5  rs1
sequencer_rf_addr_b  out  5  rs2
sequencer_rf_write_addr  out  5  rd
sequencer_rf_write_en  out  1  register-file write strobe
sequencer_immediate  out  12  instr[31:20]
sequencer_mux_0_sel  out  1  ALU operand B: 0 rf port B, 1 immediate
sequencer_mux_1_sel  out  1  writeback source: 0 ALU, 1 memory data
sequencer_mux_2_sel  out  1  immediate extension: 0 sign, 1 zero
sequencer_alu_operation  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SLT
sequencer_done  out  1  one-cycle completion pulse
sequencer_illegal  out  1  one-cycle unsupported-instruction pulse
sequencer_timeout  out  1  one-cycle memory timeout pulse
sequencer_retired  out  COUNT_WIDTH  completed-instruction count

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0, including instr_ready and retired; instruction register cleared.
- States: IDLE, DECODE, EXECUTE, MEM, WRITEBACK.
- IDLE:
  - instr_ready=1 (0 while reset asserted).
  - Handshake edge E0 (valid&ready) latches instr and moves to DECODE.
  - valid while not IDLE is ignored (ready=0).
- DECODE, one cycle:
  - Supported opcodes:
    - OP 0110011, funct7=0000000: ADD/SLL/SLT/XOR/SRL/OR/AND.
    - OP 0110011, funct7=0100000 with funct3=000: SUB.
    - OP-IMM 0010011: ADDI/SLTI/XORI/ORI/ANDI.
    - OP-IMM 0010011: SLLI/SRLI, only with instr[31:26]=0.
    - LOAD 0000011 with funct3=011: LD.
  - All else is illegal: illegal=1 for the cycle after E1, return IDLE, no write, no retire.
- Control outputs:
  - 0 in IDLE/DECODE.
  - Driven from EXECUTE entry through last WRITEBACK cycle; held stable across EXECUTE/MEM/WRITEBACK.
- Per-class settings:
  - R-type: mux_0=0.
  - I-type ALU: mux_0=1; mux_2=1 for SLLI/SRLI, else 0.
  - LD: mux_0=1, mux_1=1, alu=ADD.
  - addr_b = instr[24:20] for R-type, 0 otherwise.
- EXECUTE, one cycle: ALU ops go to WRITEBACK; LD goes to MEM.
- MEM:
  - mem_req=1 until mem_ack sampled high, then WRITEBACK.
  - mem_ack outside MEM is ignored.
- WRITEBACK, one cycle:
  - rf_write_en=1 unless rd=0.
  - done=1.
  - retired increments (including rd=0), wraps at 2^COUNT_WIDTH.
  - Then IDLE.
- Latency:
  - ALU instruction: write_en/done in the cycle after E2; instr_ready again after E3.
  - LD: WRITEBACK is the cycle after the edge that samples mem_ack.
- Reset mid-operation: aborts immediately; no write, no done, retired cleared.

Optional Feature:
SEQUENCER_TIMEOUT_EN.
- Defined:
  - MEM counts cycles with mem_ack low.
  - After TIMEOUT_CYCLES cycles: drop mem_req, timeout=1 for one cycle, return IDLE; no write, no retire.
  - Counter clears on MEM entry.
- Undefined: MEM waits indefinitely; sequencer_timeout tied 0.

Test Plan:
1. ADD x3,x1,x2 (0x002081B3) → after E2: addr_a=1, addr_b=2, write_addr=3, alu=000, mux_0=0, write_en=1, done=1; retired=1.
2. ADDI x5,x0,-1 (0xFFF00293) → immediate=0xFFF, mux_0=1, mux_2=0, alu=000, write_addr=5; SLLI x1,x1,3 (0x00309093) → alu=101, mux_2=1, immediate=0x003.
3. LD x6,8(x1) (0x0080B303), mem_ack high on third MEM cycle → mem_req high exactly 3 cycles, mux_1=1, immediate=0x008, write_en next cycle.
4. 0x40005013 (SRAI) and 0x00000000 → illegal pulse, no write_en, no done, retired unchanged, ready after 2 cycles.
5. SUB x0,x0,x0 (0x40000033) → alu=001, write_en stays 0, done=1, retired increments; valid held during execution is not accepted twice.
6. rst_n low during MEM → outputs 0 asynchronously, retired=0. With SEQUENCER_TIMEOUT_EN and no ack: mem_req falls after 255 cycles, timeout pulses once, no write.
